// File: rtl/pipe_sched.sv
// ---------------------------------------------------------------------------------------------
// pipe_sched: allocator / retirement tracker for a set of parallel speculative pipes.
//
// Each pipe is FREE, ACTIVE or DRAIN. Live pipes form a single chain rooted at the primary
// (non-speculative) pipe, where every pipe has at most one live child. A fork hands the lowest
// free pipe to the alternate path of a branch in an active parent. A resolve either squashes
// the child together with everything below it (keep=0), or squashes the parent and splices the
// child into the parent's place in the chain (keep=1). A squashed pipe drains for drain_cycles
// cycles and then returns to FREE.
//
// Parameters
//   s_pipe_cnt   number of pipes (default 3)
//   drain_cycles cycles a squashed pipe spends in DRAIN, minimum 1 (default 4)
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset: pipe 0 ACTIVE and root, all others FREE
//   fork_valid_i     request a spare pipe for a branch in pipe fork_parent_i
//   fork_parent_i    requesting pipe id
//   fork_ready_o     a FREE pipe exists and no halt is pending
//   fork_ack_o       fork accepted this cycle (combinational)
//   fork_pipe_o      child pipe id, valid with fork_ack_o (combinational)
//   resolve_valid_i  branch that created child resolve_pipe_i has resolved
//   resolve_pipe_i   child pipe id being resolved
//   resolve_keep_i   1: child path correct, parent squashed; 0: child squashed
//   pipe_en_o        per-pipe enable, 1 while ACTIVE
//   pipe_flush_o     per-pipe flush, 1 while in DRAIN
//   primary_o        root pipe id
//   halt_req_i       debug halt request
//   halted_o         speculation retired and forks blocked
//
// Configuration
//   PIPE_SCHED_HALT_EN  when defined, halt_req_i blocks forks and halted_o reports quiescence.
//                       When undefined, halt_req_i is ignored and halted_o is tied low.
// ---------------------------------------------------------------------------------------------
module pipe_sched #(
    parameter int unsigned s_pipe_cnt   = 3,
    parameter int unsigned drain_cycles = 4,
    localparam int unsigned PW = (s_pipe_cnt > 1) ? $clog2(s_pipe_cnt) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fork_valid_i,
    input  logic [PW-1:0]         fork_parent_i,
    output logic                  fork_ready_o,
    output logic                  fork_ack_o,
    output logic [PW-1:0]         fork_pipe_o,
    input  logic                  resolve_valid_i,
    input  logic [PW-1:0]         resolve_pipe_i,
    input  logic                  resolve_keep_i,
    output logic [s_pipe_cnt-1:0] pipe_en_o,
    output logic [s_pipe_cnt-1:0] pipe_flush_o,
    output logic [PW-1:0]         primary_o,
    input  logic                  halt_req_i,
    output logic                  halted_o
);

    localparam int unsigned CW = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;
    // Counter is loaded with drain_cycles-1 and the pipe frees on the cycle after it hits 0,
    // giving exactly drain_cycles cycles of DRAIN.
    localparam logic [CW-1:0] DrainLoad = CW'(drain_cycles - 1);

    typedef enum logic [1:0] {
        StFree,
        StActive,
        StDrain
    } pipe_st_e;

    // Per-pipe state
    pipe_st_e              state_q  [s_pipe_cnt];
    pipe_st_e              state_d  [s_pipe_cnt];
    logic     [PW-1:0]     parent_q [s_pipe_cnt];
    logic     [PW-1:0]     parent_d [s_pipe_cnt];
    logic     [CW-1:0]     cnt_q    [s_pipe_cnt];
    logic     [CW-1:0]     cnt_d    [s_pipe_cnt];
    logic [s_pipe_cnt-1:0] has_child_q, has_child_d;
    logic [PW-1:0]         primary_q, primary_d;

    // Decoded per-pipe views
    logic [s_pipe_cnt-1:0] active, draining, free_vec;
    logic [s_pipe_cnt-1:0] root_hit, res_hit, res_par_hit, par_hit, fork_hit;
    logic [s_pipe_cnt-1:0] squash;
    logic [PW-1:0]         res_par, res_grand;
    logic                  res_ok;
    logic                  any_free;
    logic                  halt_block;

    // ------------------------------------------------------------------------------------------
    // Decode: resolve qualification, squash set, fork grant
    // ------------------------------------------------------------------------------------------
    always_comb begin
        logic [s_pipe_cnt-1:0] sq;
        logic                  found;

        active      = '0;
        draining    = '0;
        free_vec    = '0;
        root_hit    = '0;
        res_hit     = '0;
        res_par_hit = '0;
        par_hit     = '0;
        fork_hit    = '0;
        res_par     = '0;
        res_grand   = '0;
        fork_pipe_o = '0;
        found       = 1'b0;
        sq          = '0;

        for (int unsigned i = 0; i < s_pipe_cnt; i++) begin
            active[i]   = (state_q[i] == StActive);
            draining[i] = (state_q[i] == StDrain);
            free_vec[i] = (state_q[i] == StFree);
            root_hit[i] = (primary_q == PW'(i));
            res_hit[i]  = (resolve_pipe_i == PW'(i));
            par_hit[i]  = (fork_parent_i == PW'(i));
            if (res_hit[i]) begin
                res_par = parent_q[i];
            end
            // Priority pick of the lowest-index free pipe
            if (free_vec[i] && !found) begin
                fork_pipe_o = PW'(i);
                fork_hit[i] = 1'b1;
                found       = 1'b1;
            end
        end

        for (int unsigned i = 0; i < s_pipe_cnt; i++) begin
            res_par_hit[i] = (res_par == PW'(i));
            if (res_par_hit[i]) begin
                res_grand = parent_q[i];
            end
        end

        any_free = |free_vec;

        // Out-of-range ids never hit, so they are ignored along with FREE/DRAIN/root targets.
        res_ok = resolve_valid_i && |(res_hit & active) && !(|(res_hit & root_hit));

        if (res_ok) begin
            if (resolve_keep_i) begin
                sq = res_par_hit;
            end else begin
                // Walk down the chain: each pass can add the next descendant.
                sq = res_hit;
                for (int unsigned k = 1; k < s_pipe_cnt; k++) begin
                    for (int unsigned j = 0; j < s_pipe_cnt; j++) begin
                        if (active[j] && !root_hit[j] && !sq[j]) begin
                            for (int unsigned m = 0; m < s_pipe_cnt; m++) begin
                                if (sq[m] && (parent_q[j] == PW'(m))) begin
                                    sq[j] = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
        squash = sq;

        fork_ready_o = any_free && !halt_block;
        // Reset overrides any same-cycle fork; a parent squashed this cycle cannot fork.
        fork_ack_o   = fork_valid_i && fork_ready_o && !rst_i &&
                       |(par_hit & active & ~has_child_q & ~sq);
    end

    // ------------------------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        parent_d    = parent_q;
        cnt_d       = cnt_q;
        has_child_d = has_child_q;
        primary_d   = primary_q;

        for (int unsigned i = 0; i < s_pipe_cnt; i++) begin
            if (state_q[i] == StDrain) begin
                if (cnt_q[i] == '0) begin
                    state_d[i] = StFree;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end

            if (squash[i]) begin
                state_d[i]     = StDrain;
                cnt_d[i]       = DrainLoad;
                has_child_d[i] = 1'b0;
            end

            // keep=0: the surviving parent loses its child
            if (res_ok && !resolve_keep_i && res_par_hit[i]) begin
                has_child_d[i] = 1'b0;
            end

            // keep=1: the child takes over its parent's place in the chain
            if (res_ok && resolve_keep_i && res_hit[i]) begin
                parent_d[i] = res_grand;
            end

            if (fork_ack_o && fork_hit[i]) begin
                state_d[i]     = StActive;
                parent_d[i]    = fork_parent_i;
                has_child_d[i] = 1'b0;
                cnt_d[i]       = '0;
            end

            if (fork_ack_o && par_hit[i]) begin
                has_child_d[i] = 1'b1;
            end
        end

        if (res_ok && resolve_keep_i && (res_par == primary_q)) begin
            primary_d = resolve_pipe_i;
        end
    end

    // ------------------------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < s_pipe_cnt; i++) begin
                state_q[i]  <= (i == 0) ? StActive : StFree;
                parent_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            has_child_q <= '0;
            primary_q   <= '0;
        end else begin
            state_q     <= state_d;
            parent_q    <= parent_d;
            cnt_q       <= cnt_d;
            has_child_q <= has_child_d;
            primary_q   <= primary_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------------------------
    assign pipe_en_o    = active;
    assign pipe_flush_o = draining;
    assign primary_o    = primary_q;

`ifdef PIPE_SCHED_HALT_EN
    assign halt_block = halt_req_i;
    // With forks blocked the quiescent condition cannot be lost again while halt is held.
    assign halted_o   = halt_req_i && ((active & ~root_hit) == '0) && (draining == '0);
`else
    logic unused_halt_req;
    assign unused_halt_req = halt_req_i;
    assign halt_block      = 1'b0;
    assign halted_o        = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched (s_pipe_cnt=3, drain_cycles=2): directed scenarios followed by random
// traffic, all compared against a chain-level reference model.
module tb_pipe_sched;

    localparam int N = 3;
    localparam int D = 2;
`ifdef PIPE_SCHED_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    localparam int MFree  = 0;
    localparam int MAct   = 1;
    localparam int MDrain = 2;

    logic         clk;
    logic         rst;
    logic         fork_valid;
    logic [1:0]   fork_parent;
    logic         fork_ready;
    logic         fork_ack;
    logic [1:0]   fork_pipe;
    logic         resolve_valid;
    logic [1:0]   resolve_pipe;
    logic         resolve_keep;
    logic [N-1:0] pipe_en;
    logic [N-1:0] pipe_flush;
    logic [1:0]   primary;
    logic         halt_req;
    logic         halted;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_sched #(
        .s_pipe_cnt  (N),
        .drain_cycles(D)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fork_valid_i   (fork_valid),
        .fork_parent_i  (fork_parent),
        .fork_ready_o   (fork_ready),
        .fork_ack_o     (fork_ack),
        .fork_pipe_o    (fork_pipe),
        .resolve_valid_i(resolve_valid),
        .resolve_pipe_i (resolve_pipe),
        .resolve_keep_i (resolve_keep),
        .pipe_en_o      (pipe_en),
        .pipe_flush_o   (pipe_flush),
        .primary_o      (primary),
        .halt_req_i     (halt_req),
        .halted_o       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pipe status, parent of each live pipe, remaining drain cycles, root id.
    // A parent "has a child" exactly when some live non-root pipe names it as parent.
    int m_state [N];
    int m_parent[N];
    int m_left  [N];
    int m_primary;

    bit e_ready, e_ack, e_halted, e_res_ok;
    int e_pipe, e_par;
    bit e_sq[N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_has_child(input int p);
        for (int j = 0; j < N; j++) begin
            if (j != m_primary && m_state[j] == MAct && m_parent[j] == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i]  = (i == 0) ? MAct : MFree;
            m_parent[i] = 0;
            m_left[i]   = 0;
        end
        m_primary = 0;
    endtask

    // Combinational expectations for the current model state and current inputs.
    task automatic model_eval();
        int  rp, fp, cur, nxt;
        bit  any_free, quiet;
        rp = int'(resolve_pipe);
        fp = int'(fork_parent);
        for (int i = 0; i < N; i++) e_sq[i] = 1'b0;
        e_pipe = -1;
        for (int i = N - 1; i >= 0; i--) if (m_state[i] == MFree) e_pipe = i;
        any_free = (e_pipe >= 0);

        e_res_ok = resolve_valid && rp < N && m_state[rp] == MAct && rp != m_primary;
        e_par    = e_res_ok ? m_parent[rp] : 0;
        if (e_res_ok) begin
            if (resolve_keep) begin
                e_sq[e_par] = 1'b1;
            end else begin
                e_sq[rp] = 1'b1;
                cur = rp;
                for (int s = 0; s < N; s++) begin
                    nxt = -1;
                    for (int j = 0; j < N; j++)
                        if (j != m_primary && j != cur && m_state[j] == MAct && m_parent[j] == cur)
                            nxt = j;
                    if (nxt < 0) break;
                    e_sq[nxt] = 1'b1;
                    cur = nxt;
                end
            end
        end

        e_ready = any_free && !(HaltEn && halt_req);
        e_ack   = !rst && fork_valid && e_ready && fp < N && m_state[fp] == MAct &&
                  !m_has_child(fp) && !e_sq[fp];

        quiet = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m_state[i] == MDrain) quiet = 1'b0;
            if (m_state[i] == MAct && i != m_primary) quiet = 1'b0;
        end
        e_halted = HaltEn && halt_req && quiet;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            model_eval();
            for (int i = 0; i < N; i++) begin
                if (m_state[i] == MDrain) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_state[i] = MFree;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (e_sq[i]) begin
                    m_state[i] = MDrain;
                    m_left[i]  = D;
                end
            end
            if (e_res_ok && resolve_keep) begin
                m_parent[resolve_pipe] = m_parent[e_par];
                if (e_par == m_primary) m_primary = int'(resolve_pipe);
            end
            if (e_ack) begin
                m_state[e_pipe]  = MAct;
                m_parent[e_pipe] = int'(fork_parent);
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] x_en, x_fl;
        model_eval();
        for (int i = 0; i < N; i++) begin
            x_en[i] = (m_state[i] == MAct);
            x_fl[i] = (m_state[i] == MDrain);
        end
        check_eq("pipe_en", 32'(pipe_en), 32'(x_en));
        check_eq("pipe_flush", 32'(pipe_flush), 32'(x_fl));
        check_eq("primary", 32'(primary), 32'(m_primary));
        check_eq("fork_ready", 32'(fork_ready), 32'(e_ready));
        check_eq("fork_ack", 32'(fork_ack), 32'(e_ack));
        if (e_ack) check_eq("fork_pipe", 32'(fork_pipe), 32'(e_pipe));
        check_eq("halted", 32'(halted), 32'(e_halted));
    endtask

    // One clock: advance the model over the edge, then apply new inputs mid-cycle and compare.
    task automatic drive_cycle(input bit r, input bit fv, input int fp, input bit rv,
                               input int rp, input bit rk, input bit hr);
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst           = r;
        fork_valid    = fv;
        fork_parent   = 2'(fp);
        resolve_valid = rv;
        resolve_pipe  = 2'(rp);
        resolve_keep  = rk;
        halt_req      = hr;
        #1;
        check_outputs();
    endtask

    initial begin
        bit hr_rand;
        rst           = 1'b1;
        fork_valid    = 1'b0;
        fork_parent   = '0;
        resolve_valid = 1'b0;
        resolve_pipe  = '0;
        resolve_keep  = 1'b0;
        halt_req      = 1'b0;
        model_reset();

        // Reset release
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_en", 32'(pipe_en), 32'h1);
        check_eq("rst_flush", 32'(pipe_flush), 32'h0);
        check_eq("rst_primary", 32'(primary), 32'h0);
        check_eq("rst_ready", 32'(fork_ready), 32'h1);
        check_eq("rst_ack", 32'(fork_ack), 32'h0);

        // Fork from root, then a second fork from the same parent is refused
        drive_cycle(0, 1, 0, 0, 0, 0, 0);
        check_eq("fork1_ack", 32'(fork_ack), 32'h1);
        check_eq("fork1_pipe", 32'(fork_pipe), 32'h1);
        drive_cycle(0, 1, 0, 0, 0, 0, 0);
        check_eq("fork1_en", 32'(pipe_en), 32'h3);
        check_eq("fork_dup_ack", 32'(fork_ack), 32'h0);

        // Chain 0->1->2, squash 1 and its descendant
        drive_cycle(0, 1, 1, 0, 0, 0, 0);
        check_eq("fork2_pipe", 32'(fork_pipe), 32'h2);
        drive_cycle(0, 0, 0, 1, 1, 0, 0);
        check_eq("chain_en", 32'(pipe_en), 32'h7);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("sq_flush_a", 32'(pipe_flush), 32'h6);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("sq_flush_b", 32'(pipe_flush), 32'h6);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("sq_done_en", 32'(pipe_en), 32'h1);
        check_eq("sq_done_flush", 32'(pipe_flush), 32'h0);
        check_eq("sq_done_ready", 32'(fork_ready), 32'h1);

        // Chain 0->1, keep child: pipe 1 becomes primary, pipe 0 drains and is reused
        drive_cycle(0, 1, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 1, 1, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("keep_primary", 32'(primary), 32'h1);
        check_eq("keep_flush_a", 32'(pipe_flush), 32'h1);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("keep_flush_b", 32'(pipe_flush), 32'h1);
        drive_cycle(0, 1, 1, 0, 0, 0, 0);
        check_eq("keep_flush_c", 32'(pipe_flush), 32'h0);
        check_eq("reuse_ack", 32'(fork_ack), 32'h1);
        check_eq("reuse_pipe", 32'(fork_pipe), 32'h0);

        // Same-cycle squash of the forking parent drops the fork
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 1, 0, 0, 0, 0, 0);
        drive_cycle(0, 1, 1, 1, 1, 0, 0);
        check_eq("race_ack", 32'(fork_ack), 32'h0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("race_en", 32'(pipe_en), 32'h1);
        check_eq("race_flush", 32'(pipe_flush), 32'h2);

`ifdef PIPE_SCHED_HALT_EN
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 1, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1);
        check_eq("halt_ready", 32'(fork_ready), 32'h0);
        drive_cycle(0, 0, 0, 1, 1, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 0, 1);
        check_eq("halt_wait_a", 32'(halted), 32'h0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1);
        check_eq("halt_wait_b", 32'(halted), 32'h0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1);
        check_eq("halt_done", 32'(halted), 32'h1);
`endif

        // Random traffic
        hr_rand = 1'b0;
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) hr_rand = ~hr_rand;
            drive_cycle($urandom_range(0, 149) == 0,
                        $urandom_range(0, 1) == 1,
                        int'($urandom_range(0, 3)),
                        $urandom_range(0, 3) == 0,
                        int'($urandom_range(0, 3)),
                        $urandom_range(0, 1) == 1,
                        hr_rand);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_sched.md
PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 Parameter s_pipe_cnt, default 3: number of parallel speculative pipes; PW = $clog2(s_pipe_cnt).
REQ-002 Parameter drain_cycles, default 4: cycles a squashed pipe stays in DRAIN before it is reusable; minimum 1.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 fork_valid  in  1  a branch in pipe fork_parent requests a spare pipe for its alternate path.
REQ-006 fork_parent  in  PW  id of the requesting pipe.
REQ-007 fork_ready  out  1  at least one pipe is FREE and no halt is pending.
REQ-008 fork_ack  out  1  fork accepted this cycle.
REQ-009 fork_pipe  out  PW  id of the allocated child; valid when fork_ack=1.
REQ-010 resolve_valid  in  1  the branch that created child resolve_pipe has resolved.
REQ-011 resolve_pipe  in  PW  child pipe id being resolved.
REQ-012 resolve_keep  in  1  1 = child path correct (parent squashed); 0 = child path wrong (child squashed).
REQ-013 pipe_en  out  s_pipe_cnt  per-pipe stage enable; 1 when the pipe is ACTIVE.
REQ-014 pipe_flush  out  s_pipe_cnt  per-pipe flush; 1 when the pipe is in DRAIN.
REQ-015 primary  out  PW  id of the root (non-speculative) pipe.
REQ-016 halt_req  in  1  debug halt request.
REQ-017 halted  out  1  all speculation retired and forks blocked.

Function
REQ-018 Per-pipe state: FREE, ACTIVE, DRAIN; per-pipe parent link and has_child flag; one pipe is the root, with no parent.
REQ-019 A pipe has at most one live child; pipes form a single chain rooted at primary.
REQ-020 fork_ack = fork_valid & fork_ready & parent ACTIVE & parent has no child & parent not squashed this cycle; fork_pipe = lowest-index FREE pipe; fork_ack and fork_pipe are combinational in the same cycle.
REQ-021 On fork_ack: next cycle the child is ACTIVE, its parent link = fork_parent, and fork_parent.has_child = 1.
REQ-022 Resolve with keep=0: next cycle the child and all its descendants enter DRAIN, and the parent's has_child clears.
REQ-023 Resolve with keep=1: next cycle the parent enters DRAIN; the child inherits the parent's parent link, and becomes primary if the parent was root; the child's descendants are untouched.
REQ-024 A resolve is ignored if resolve_pipe is not ACTIVE or is the root.
REQ-025 DRAIN lasts exactly drain_cycles cycles, then FREE; a freed pipe is grantable in the cycle it reads FREE.
REQ-026 Same-cycle fork and resolve: the resolve is evaluated first; a pipe entering DRAIN is never granted; a fork whose parent is squashed by that resolve is dropped (fork_ack=0).
REQ-027 No FREE pipe: fork_ready=0, fork_ack=0, no state change.
REQ-028 pipe_en and pipe_flush are never both 1 for the same pipe.

Reset
REQ-029 On rst: pipe 0 is ACTIVE and root; all other pipes FREE; links and has_child cleared; drain counters 0; primary=0; halted=0.
REQ-030 After rst: fork_ready=1 when s_pipe_cnt>1; fork_ack=0 until fork_valid; pipe_flush=0.
REQ-031 rst mid-DRAIN or mid-halt aborts it and overrides all same-cycle fork and resolve inputs.

Configuration
REQ-032 Macro PIPE_SCHED_HALT_EN defined: halt_req forces fork_ready=0; halted=1 once only the root is ACTIVE and no pipe is in DRAIN, and stays 1 while halt_req=1; in-flight resolves still complete.
REQ-033 Macro undefined: halt_req is ignored, halted is tied 0, and fork_ready depends only on FREE availability.

Verification (s_pipe_cnt=3, drain_cycles=2)
REQ-034 Reset release -> pipe_en=3'b001, pipe_flush=0, primary=0, fork_ready=1.
REQ-035 fork_valid, parent=0 -> fork_ack=1, fork_pipe=1; next cycle pipe_en=3'b011; a second fork from 0 -> fork_ack=0.
REQ-036 Chain 0->1->2, resolve pipe 1 keep=0 -> next cycle pipe_flush=3'b110 for 2 cycles, then pipe_en=3'b001, fork_ready=1.
REQ-037 Chain 0->1, resolve pipe 1 keep=1 -> primary=1, pipe_flush=3'b001 for 2 cycles, pipe 0 then FREE and granted on the next fork.
REQ-038 Chain 0->1, same cycle resolve 1 keep=0 plus fork from parent 1 -> fork_ack=0, pipe 2 stays FREE.
REQ-039 With PIPE_SCHED_HALT_EN: halt_req during chain 0->1, then resolve 1 keep=0 -> fork_ready=0, halted=1 two cycles after the resolve takes effect.
